// File: rtl/fetch_decode.sv
// Fetch/decode stage of the mini CPU: owns the PC, fetches and classifies instructions,
// reads operands, resolves JMP/HALT locally and hands everything else to execute.
module fetch_decode #(
    parameter int PC_W   = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              run_i,
    output logic [PC_W-1:0]   imem_addr_o,
    output logic              imem_req_o,
    input  logic [15:0]       imem_rdata_i,
    input  logic              imem_valid_i,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic              dmem_req_o,
    input  logic [15:0]       dmem_rdata_i,
    input  logic              dmem_valid_i,
    output logic              start_o,
    output logic [1:0]        iden_o,
    output logic [3:0]        opcode_o,
    output logic [15:0]       operand_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              busy_o,
    output logic              halted_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPER, S_ISSUE, S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [1:0]        iden_q, iden_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [15:0]       operand_q, operand_d;

    logic [1:0]        ir_iden;
    logic [3:0]        ir_opc;
    logic              is_halt;
    logic              is_jmp;
    logic              no_oper;

    assign ir_iden = ir_q[15:14];
    assign ir_opc  = ir_q[13:10];
    assign is_halt = (ir_iden == 2'b11) && (ir_opc == 4'b1111);
    assign is_jmp  = (ir_iden == 2'b10);
    // These arith/shift opcodes take no memory operand, so OPER is skipped.
    assign no_oper = (ir_iden == 2'b01) &&
                     ((ir_opc == 4'b0110) || (ir_opc == 4'b0111) ||
                      (ir_opc == 4'b1000) || (ir_opc == 4'b1111));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            iden_q    <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            iden_q    <= iden_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        iden_d     = iden_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        start_o    = 1'b0;
        busy_o     = 1'b0;
        halted_o   = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                halted_o = (state_q == S_HALTED);
                if (run_i) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                busy_o     = 1'b1;
                if (imem_valid_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy_o = 1'b1;
                if (is_halt) begin
                    state_d = S_HALTED;
                end else if (is_jmp) begin
                    pc_d    = ir_q[PC_W-1:0];
                    state_d = S_FETCH;
                end else if (no_oper) begin
                    iden_d   = ir_iden;
                    opcode_d = ir_opc;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_OPER;
                end
            end
            S_OPER: begin
                dmem_req_o = 1'b1;
                busy_o     = 1'b1;
                if (dmem_valid_i) begin
                    operand_d = dmem_rdata_i;
                    iden_d    = ir_iden;
                    opcode_d  = ir_opc;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_o = 1'b1;
                busy_o  = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr_o = pc_q;
    assign dmem_addr_o = ir_q[ADDR_W-1:0];
    assign iden_o      = iden_q;
    assign opcode_o    = opcode_q;
    assign operand_o   = operand_q;
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: an ISA-level program interpreter predicts the fetch
// address stream and every START; memory responders and a monitor check the DUT against it.
module tb_fetch_decode;

    typedef struct packed {
        logic [1:0]  id;
        logic [3:0]  op;
        logic [15:0] opnd;
        logic [7:0]  pc;
    } issue_t;

    logic        clk, rst_n, run;
    logic [7:0]  imem_addr;
    logic        imem_req, imem_valid;
    logic [15:0] imem_rdata;
    logic [9:0]  dmem_addr;
    logic        dmem_req, dmem_valid;
    logic [15:0] dmem_rdata;
    logic        start, busy, halted;
    logic [1:0]  iden;
    logic [3:0]  opcode;
    logic [15:0] operand;
    logic [7:0]  pc;

    fetch_decode #(.PC_W(8), .ADDR_W(10)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run),
        .imem_addr_o(imem_addr), .imem_req_o(imem_req),
        .imem_rdata_i(imem_rdata), .imem_valid_i(imem_valid),
        .dmem_addr_o(dmem_addr), .dmem_req_o(dmem_req),
        .dmem_rdata_i(dmem_rdata), .dmem_valid_i(dmem_valid),
        .start_o(start), .iden_o(iden), .opcode_o(opcode), .operand_o(operand),
        .pc_o(pc), .busy_o(busy), .halted_o(halted)
    );

    logic [15:0] imem [256];
    logic [15:0] dmem [1024];
    issue_t      sq[$];
    logic [7:0]  fq[$];
    logic [15:0] m_operand;
    int          tests, fails, cyc, run_cyc, first_start_cyc, dreq_cnt;
    int          imem_lat, dmem_lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Instruction memory: latency counted from the first REQ cycle, junk VALIDs when idle
    initial begin
        bit         pend;
        int         cnt;
        logic [7:0] a0;
        pend = 0; cnt = 0; a0 = 0;
        imem_valid = 1'b0; imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (imem_req === 1'b1) begin
                if (!pend) begin
                    pend = 1; a0 = imem_addr;
                    cnt = (imem_lat < 0) ? int'($urandom_range(0, 3)) : imem_lat;
                    if (fq.size() != 0) check("fetch_addr", imem_addr, fq.pop_front());
                end else begin
                    check("imem_addr_stable", imem_addr, a0);
                end
                if (cnt == 0) begin
                    imem_valid = 1'b1; imem_rdata = imem[imem_addr];
                end else begin
                    cnt--;
                    imem_valid = 1'b0; imem_rdata = 16'($urandom);
                end
            end else begin
                pend = 0;
                imem_valid = 1'($urandom); imem_rdata = 16'($urandom);
            end
        end
    end

    initial begin
        bit         pend;
        int         cnt;
        logic [9:0] a0;
        pend = 0; cnt = 0; a0 = 0;
        dmem_valid = 1'b0; dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (dmem_req === 1'b1) begin
                dreq_cnt++;
                if (!pend) begin
                    pend = 1; a0 = dmem_addr;
                    cnt = (dmem_lat < 0) ? int'($urandom_range(0, 3)) : dmem_lat;
                end else begin
                    check("dmem_addr_stable", dmem_addr, a0);
                end
                if (cnt == 0) begin
                    dmem_valid = 1'b1; dmem_rdata = dmem[dmem_addr];
                end else begin
                    cnt--;
                    dmem_valid = 1'b0; dmem_rdata = 16'($urandom);
                end
            end else begin
                pend = 0;
                dmem_valid = 1'($urandom); dmem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: every START must match the next predicted issue
    initial begin
        bit     prev;
        issue_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (start === 1'b1) begin
                check("start_back_to_back", 32'(prev), 32'd0);
                if (first_start_cyc < 0) first_start_cyc = cyc;
                if (sq.size() == 0) begin
                    check("start_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sq.pop_front();
                    check("issue", {iden, opcode, operand, pc}, {e.id, e.op, e.opnd, e.pc});
                end
            end
            prev = (start === 1'b1);
        end
    end

    // Reference: interpret the program; the last allowed fetch is observed but not executed
    task automatic build_model(input int max_fetch, output bit halts, output logic [7:0] fin_pc);
        logic [7:0]  p;
        logic [15:0] ins;
        logic [1:0]  id;
        logic [3:0]  op;
        p = 0; halts = 0; fin_pc = 0;
        for (int n = 0; n < max_fetch; n++) begin
            fq.push_back(p);
            if (n == max_fetch - 1) break;
            ins = imem[p]; id = ins[15:14]; op = ins[13:10];
            if (id == 2'd3 && op == 4'd15) begin
                halts = 1; fin_pc = p;
                return;
            end
            if (id == 2'd2) begin
                p = ins[7:0];
                continue;
            end
            if (!(id == 2'd1 && (op == 4'd6 || op == 4'd7 || op == 4'd8 || op == 4'd15)))
                m_operand = dmem[ins[9:0]];
            sq.push_back('{id: id, op: op, opnd: m_operand, pc: p});
            p = p + 8'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_operand = '0;
    endtask

    task automatic run_prog(input int max_fetch, input int exp_delta, input string nm);
        bit         h;
        logic [7:0] fpc;
        sq.delete(); fq.delete();
        build_model(max_fetch, h, fpc);
        @(negedge clk);
        run = 1'b1; run_cyc = cyc; first_start_cyc = -1;
        @(negedge clk);
        run = 1'b0;
        if (h) begin
            for (int i = 0; i < 3000 && halted !== 1'b1; i++) @(negedge clk);
            check({nm, "_halted"}, 32'(halted), 32'd1);
            check({nm, "_halt_pc"}, 32'(pc), 32'(fpc));
            if (halted !== 1'b1) do_reset();
        end else begin
            for (int i = 0; i < 3000 && fq.size() != 0; i++) @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            m_operand = '0;
        end
        check({nm, "_fetches_left"}, 32'(fq.size()), 32'd0);
        check({nm, "_starts_left"}, 32'(sq.size()), 32'd0);
        if (exp_delta > 0) check({nm, "_first_start_cycle"}, 32'(first_start_cyc - run_cyc), 32'(exp_delta));
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = 16'hFC00;
    endtask

    initial begin
        logic [15:0] w;
        tests = 0; fails = 0; dreq_cnt = 0; first_start_cyc = -1; run_cyc = 0;
        imem_lat = 0; dmem_lat = 0; m_operand = '0;
        for (int i = 0; i < 1024; i++) dmem[i] = 16'($urandom);
        fill_halt();
        rst_n = 1'b0; run = 1'b1;

        // Reset held with RUN high
        repeat (2) @(negedge clk);
        check("rst_ctrl", {start, imem_req, dmem_req, busy, halted}, 5'd0);
        check("rst_data", {pc, iden, opcode, operand, imem_addr}, 38'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_fetch", {imem_req, imem_addr}, {1'b1, 8'd0});
        run = 1'b0;
        for (int i = 0; i < 50 && halted !== 1'b1; i++) @(negedge clk);
        check("rst_then_halt_pc", {halted, pc}, {1'b1, 8'd0});

        // Load with zero-wait memories
        imem[0] = 16'h0005; dmem[5] = 16'h1234;
        run_prog(100, 4, "load");

        // No-operand instruction never touches data memory
        fill_halt();
        imem[0] = 16'h5800;
        dreq_cnt = 0;
        run_prog(100, 3, "noop");
        check("noop_dmem_req", 32'(dreq_cnt), 32'd0);

        // JMP then HALT, then a restart from HALTED
        fill_halt();
        imem[0] = 16'h8003; imem[3] = 16'hFC00; imem[1] = 16'h0001;
        run_prog(100, 0, "jmp_halt");
        run_prog(100, 0, "restart");

        // Fixed wait states
        imem_lat = 3; dmem_lat = 2;
        fill_halt();
        imem[0] = 16'h0010; imem[1] = 16'h4411; imem[2] = 16'hC3FF; imem[3] = 16'h6000;
        run_prog(100, 0, "wait");

        // PC wrap through a truncated JMP target
        imem_lat = 0; dmem_lat = 0;
        fill_halt();
        imem[0] = 16'h83FE; imem[254] = 16'h5800; imem[255] = 16'h5C00;
        run_prog(4, 0, "wrap");

        // Reset during OPER suppresses the issue
        fill_halt();
        imem[0] = 16'h0005;
        dmem_lat = 6;
        sq.delete(); fq.delete();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        for (int i = 0; i < 20 && dmem_req !== 1'b1; i++) @(negedge clk);
        check("oper_reached", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("oper_rst_drop", {dmem_req, start}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1; m_operand = '0;
        repeat (10) @(negedge clk);
        check("oper_rst_idle", {busy, halted, operand}, 18'd0);

        // Random programs with random wait states
        imem_lat = -1; dmem_lat = -1;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                case ($urandom_range(0, 15))
                    0: w[15:10] = 6'b111111;
                    1, 2: w[15:14] = 2'b10;
                    3: w[15:10] = 6'b010110;
                    default: ;
                endcase
                imem[i] = w;
            end
            for (int i = 0; i < 1024; i++) dmem[i] = 16'($urandom);
            run_prog(30, 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
